// File: rtl/mips_alu_issue.sv
// Decode/issue front end for the combinational MIPS ALU: decodes instruction words,
// reads the register file with writeback bypass, retires results and resolves branches.
module mips_alu_issue #(
  parameter int DATA_W = 32,
  parameter int OP_W = 4,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] alu_instc,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_br_taken,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_addr_valid,
  input  logic              dbg_we,
  input  logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] pc,
  output logic [15:0]       retire_cnt
);

  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(7);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(11);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BR} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [32];

  logic              ex_wr_en;
  logic [4:0]        ex_wr_idx;
  logic              ex_mem;
  logic [DATA_W-1:0] ex_br_off;

  logic [4:0]        rs_idx, rt_idx;
  logic [DATA_W-1:0] sext_imm;
  logic [OP_W-1:0]   dec_op;
  logic              dec_wr_en;
  logic [4:0]        dec_wr_idx;
  logic              dec_mem;
  logic              dec_branch;
  logic [DATA_W-1:0] dec_instc;
  logic              accept;
  logic              wb_en;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign rs_idx   = instr[25:21];
  assign rt_idx   = instr[20:16];
  assign sext_imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  always_comb begin
    dec_op     = OP_NOP;
    dec_wr_en  = 1'b0;
    dec_wr_idx = rt_idx;
    dec_mem    = 1'b0;
    dec_branch = 1'b0;
    dec_instc  = sext_imm;
    if (instr[31:26] == 6'h00) begin
      dec_instc  = '0;
      dec_wr_idx = instr[15:11];
      case (instr[5:0])
        6'h22:   begin dec_op = OP_SUB; dec_wr_en = 1'b1; end
        6'h24:   begin dec_op = OP_AND; dec_wr_en = 1'b1; end
        6'h26:   begin dec_op = OP_XOR; dec_wr_en = 1'b1; end
        6'h2A:   begin dec_op = OP_SLT; dec_wr_en = 1'b1; end
        default: dec_op = OP_NOP;
      endcase
    end else begin
      case (instr[31:26])
        6'h08:   begin dec_op = OP_ADDI; dec_wr_en = 1'b1; end
        6'h04:   begin dec_op = OP_BEQ; dec_branch = 1'b1; end
        6'h05:   begin dec_op = OP_BNE; dec_branch = 1'b1; end
        6'h23:   begin dec_op = OP_LW; dec_mem = 1'b1; end
        6'h2B:   begin dec_op = OP_SW; dec_mem = 1'b1; end
        6'h0C:   begin
          dec_op    = OP_ANDI;
          dec_wr_en = 1'b1;
          dec_instc = {{(DATA_W-16){1'b0}}, instr[15:0]};
        end
        6'h0A:   begin dec_op = OP_SLTI; dec_wr_en = 1'b1; end
        default: dec_op = OP_NOP;
      endcase
    end
    if (dec_wr_idx == 5'd0) dec_wr_en = 1'b0;
  end

  // Operands forward the result retiring on this same edge instead of the stale register.
  assign wb_en  = (state == S_EXEC) && ex_wr_en;
  assign rs_val = (wb_en && ex_wr_idx == rs_idx) ? alu_result : regs[rs_idx];
  assign rt_val = (wb_en && ex_wr_idx == rt_idx) ? alu_result : regs[rt_idx];

  always_comb begin
    instr_ready = !rst && (state != S_BR);
    accept      = instr_valid && instr_ready;
    state_nxt   = state;
    case (state)
      S_IDLE, S_EXEC: state_nxt = accept ? (dec_branch ? S_BR : S_EXEC) : S_IDLE;
      S_BR:           state_nxt = S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      alu_in1        <= '0;
      alu_in2        <= '0;
      alu_instc      <= '0;
      alu_op         <= OP_NOP;
      ex_wr_en       <= 1'b0;
      ex_wr_idx      <= '0;
      ex_mem         <= 1'b0;
      ex_br_off      <= '0;
      mem_addr       <= '0;
      mem_addr_valid <= 1'b0;
      pc             <= RESET_PC;
      retire_cnt     <= '0;
    end else begin
      state          <= state_nxt;
      mem_addr_valid <= 1'b0;
      if (state != S_IDLE) retire_cnt <= retire_cnt + 16'd1;
      if (state == S_EXEC && ex_mem) begin
        mem_addr       <= alu_result;
        mem_addr_valid <= 1'b1;
      end
      // pc already points past the branch, so only the scaled offset is added.
      if (state == S_BR && alu_br_taken) pc <= pc + ex_br_off;
      if (accept) begin
        alu_in1   <= rs_val;
        alu_in2   <= rt_val;
        alu_instc <= dec_instc;
        alu_op    <= dec_op;
        ex_wr_en  <= dec_wr_en;
        ex_wr_idx <= dec_wr_idx;
        ex_mem    <= dec_mem;
        ex_br_off <= {sext_imm[DATA_W-3:0], 2'b00};
        pc        <= pc + DATA_W'(4);
      end else begin
        alu_op <= OP_NOP;
      end
    end
  end

  // Writeback is ordered after the debug port so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (dbg_we && dbg_addr != 5'd0) regs[dbg_addr] <= dbg_wdata;
      if (wb_en) regs[ex_wr_idx] <= alu_result;
    end
  end

endmodule

// File: tb/tb_mips_alu_issue.sv
// Bench for mips_alu_issue: stands in for the ALU and checks every cycle against an
// instruction-level model of the architectural registers, PC and retire count.
module tb_mips_alu_issue;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_in1, alu_in2, alu_instc;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_br_taken;
  logic [31:0] mem_addr;
  logic        mem_addr_valid;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] pc;
  logic [15:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  mips_alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_instc(alu_instc), .alu_op(alu_op), .alu_result(alu_result),
    .alu_br_taken(alu_br_taken), .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .pc(pc), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU the block drives.
  always_comb begin
    alu_result   = 32'd0;
    alu_br_taken = 1'b0;
    case (alu_op)
      4'd0:       alu_result = alu_in1 + alu_instc;
      4'd1:       alu_result = alu_in1 - alu_in2;
      4'd2:       alu_br_taken = (alu_in1 == alu_in2);
      4'd3:       alu_br_taken = (alu_in1 != alu_in2);
      4'd4, 4'd5: alu_result = alu_in1 + alu_instc;
      4'd6:       alu_result = alu_in1 & alu_in2;
      4'd7:       alu_result = alu_in1 & alu_instc;
      4'd8:       alu_result = alu_in1 ^ alu_in2;
      4'd9:       alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      4'd10:      alu_result = ($signed(alu_in1) < $signed(alu_instc)) ? 32'd1 : 32'd0;
      default:    alu_result = 32'd0;
    endcase
  end

  // Architectural model state
  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  logic [15:0] mRetire;
  logic        pValid;
  logic [31:0] pInstr, pA, pB;
  logic        brStall;
  logic [3:0]  eOp;
  logic [31:0] eIn1, eIn2, eInstc, eMemAddr;
  logic        eMemValid;

  function automatic logic [31:0] sext16(input logic [31:0] i);
    return {{16{i[15]}}, i[15:0]};
  endfunction

  function automatic logic [3:0] opOf(input logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h22: return 4'd1;
        6'h24: return 4'd6;
        6'h26: return 4'd8;
        6'h2A: return 4'd9;
        default: return 4'd11;
      endcase
    end
    case (i[31:26])
      6'h08: return 4'd0;
      6'h04: return 4'd2;
      6'h05: return 4'd3;
      6'h23: return 4'd4;
      6'h2B: return 4'd5;
      6'h0C: return 4'd7;
      6'h0A: return 4'd10;
      default: return 4'd11;
    endcase
  endfunction

  // Destination register of an instruction; 0 means nothing is written.
  function automatic logic [4:0] isaDest(input logic [31:0] i);
    if (i[31:26] == 6'h00)
      return (i[5:0] inside {6'h22, 6'h24, 6'h26, 6'h2A}) ? i[15:11] : 5'd0;
    return (i[31:26] inside {6'h08, 6'h0C, 6'h0A}) ? i[20:16] : 5'd0;
  endfunction

  function automatic logic [31:0] isaValue(input logic [31:0] i, input logic [31:0] a,
                                           input logic [31:0] b);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h22: return a - b;
        6'h24: return a & b;
        6'h26: return a ^ b;
        6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
    case (i[31:26])
      6'h08, 6'h23, 6'h2B: return a + sext16(i);
      6'h0C: return a & {16'h0, i[15:0]};
      6'h0A: return ($signed(a) < $signed(sext16(i))) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelEdge(input logic r, input logic v, input logic [31:0] ins,
                           input logic dwe, input logic [4:0] da, input logic [31:0] dd);
    logic [4:0]  d;
    logic [31:0] val;
    logic        readyNow;
    readyNow = !brStall;
    if (r) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mPc = 32'd0; mRetire = 16'd0; pValid = 1'b0; brStall = 1'b0;
      eOp = 4'd11; eIn1 = 32'd0; eIn2 = 32'd0; eInstc = 32'd0;
      eMemValid = 1'b0; eMemAddr = 32'd0;
    end else begin
      eMemValid = 1'b0;
      d = 5'd0;
      val = 32'd0;
      if (pValid) begin
        mRetire = mRetire + 16'd1;
        val = isaValue(pInstr, pA, pB);
        d = isaDest(pInstr);
        if (pInstr[31:26] == 6'h23 || pInstr[31:26] == 6'h2B) begin
          eMemValid = 1'b1;
          eMemAddr = val;
        end
        if ((pInstr[31:26] == 6'h04 && pA == pB) || (pInstr[31:26] == 6'h05 && pA != pB))
          mPc = mPc + (sext16(pInstr) << 2);
      end
      if (dwe && da != 5'd0 && da != d) mRegs[da] = dd;
      if (d != 5'd0) mRegs[d] = val;
      pValid = 1'b0;
      if (v && readyNow) begin
        pA = mRegs[ins[25:21]];
        pB = mRegs[ins[20:16]];
        eIn1 = pA;
        eIn2 = pB;
        eOp = opOf(ins);
        eInstc = (ins[31:26] == 6'h00) ? 32'd0 :
                 (ins[31:26] == 6'h0C) ? {16'h0, ins[15:0]} : sext16(ins);
        mPc = mPc + 32'd4;
        pValid = 1'b1;
        pInstr = ins;
        brStall = (ins[31:26] == 6'h04 || ins[31:26] == 6'h05);
      end else begin
        eOp = 4'd11;
        brStall = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".instr_ready"}, 32'(instr_ready), 32'(!rst && !brStall));
    check({tag, ".alu_op"}, 32'(alu_op), 32'(eOp));
    check({tag, ".alu_in1"}, alu_in1, eIn1);
    check({tag, ".alu_in2"}, alu_in2, eIn2);
    check({tag, ".alu_instc"}, alu_instc, eInstc);
    check({tag, ".pc"}, pc, mPc);
    check({tag, ".retire_cnt"}, 32'(retire_cnt), 32'(mRetire));
    check({tag, ".mem_addr_valid"}, 32'(mem_addr_valid), 32'(eMemValid));
    check({tag, ".mem_addr"}, mem_addr, eMemAddr);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
                               input logic dwe, input logic [4:0] da,
                               input logic [31:0] dd, input string tag);
    rst = r; instr_valid = v; instr = ins;
    dbg_we = dwe; dbg_addr = da; dbg_wdata = dd;
    @(posedge clk);
    modelEdge(r, v, ins, dwe, da, dd);
    #1;
    checkOutput(tag);
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int k;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom());
    k = int'($urandom_range(0, 12));
    case (k)
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      2: return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      3: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      5: return {6'h08, rs, rt, imm};
      6: return {6'h04, rs, rt, imm};
      7: return {6'h05, rs, rt, imm};
      8: return {6'h23, rs, rt, imm};
      9: return {6'h2B, rs, rt, imm};
      10: return {6'h0C, rs, rt, imm};
      11: return {6'h0A, rs, rt, imm};
      default: return {6'h3F, rs, rt, imm};
    endcase
  endfunction

  initial begin
    logic        r, v, dwe;
    logic [4:0]  da;
    logic [31:0] dd;
    brStall = 1'b0;
    // reset held for two cycles, then the first idle cycle
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, "reset0");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, "reset1");
    // preload R1=105, R2=34, then sub $3,$1,$2 and forwarded addi $4,$3,5
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd1, 32'd105, "dbg_r1");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd2, 32'd34, "dbg_r2");
    applyStimulus(1'b0, 1'b1, 32'h00221822, 1'b0, 5'd0, 32'd0, "sub");
    applyStimulus(1'b0, 1'b1, 32'h20640005, 1'b0, 5'd0, 32'd0, "addi_bypass");
    applyStimulus(1'b0, 1'b1, 32'h00800022, 1'b0, 5'd0, 32'd0, "probe_r4");
    applyStimulus(1'b0, 1'b1, 32'hFC000000, 1'b0, 5'd0, 32'd0, "illegal");
    // branches from pc=0x10 with equal operands
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd5, 32'd5, "dbg_r5");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd6, 32'd5, "dbg_r6");
    applyStimulus(1'b0, 1'b1, 32'h10A60003, 1'b0, 5'd0, 32'd0, "beq");
    applyStimulus(1'b0, 1'b1, 32'h14A60003, 1'b0, 5'd0, 32'd0, "beq_stall");
    applyStimulus(1'b0, 1'b1, 32'h14A60003, 1'b0, 5'd0, 32'd0, "bne");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, "bne_resolve");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, "idle");
    // lw address pulse, R2 must stay 34
    applyStimulus(1'b0, 1'b1, 32'h8C220008, 1'b0, 5'd0, 32'd0, "lw");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, "lw_exec");
    applyStimulus(1'b0, 1'b1, 32'h00400022, 1'b0, 5'd0, 32'd0, "probe_r2");
    // writeback beats a debug write to the same index
    applyStimulus(1'b0, 1'b1, 32'h20070001, 1'b0, 5'd0, 32'd0, "addi_r7");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 32'd99, "dbg_r7_collide");
    applyStimulus(1'b0, 1'b1, 32'h00E00022, 1'b0, 5'd0, 32'd0, "probe_r7");
    // reset in the branch-resolve cycle
    applyStimulus(1'b0, 1'b1, 32'h10A60003, 1'b0, 5'd0, 32'd0, "beq2");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, "reset_in_br");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'd0, "after_reset");
    applyStimulus(1'b0, 1'b1, 32'h00200022, 1'b0, 5'd0, 32'd0, "probe_r1_cleared");
    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      dwe = !v && ($urandom_range(0, 1) == 1);
      da = 5'($urandom_range(0, 7));
      dd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom());
      applyStimulus(r, v, randInstr(), dwe, da, dd, $sformatf("rnd%0d", n));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
